id_ex_hazard_reg: RTL and testbench

ID_EX_HAZARD_REG -- requirements
Module: id_ex_hazard_reg

---
 rtl/mips_pkg.sv | 34 +++
 rtl/load_use_detect.sv | 25 ++
 rtl/id_ex_hazard_reg.sv | 152 +++++++++++++++
 tb/tb_id_ex_hazard_reg.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared ID/EX pipeline widths, the hazard FSM state enum and the
// packed ID/EX stage record used by the hazard register.
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int ALU_OP_W   = 3;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_BUBBLE = 1'b1
  } hz_state_e;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
    logic                  reg_write;
    logic                  mem_read;
    logic                  mem_write;
    logic                  mem_to_reg;
    logic                  alu_src;
    logic                  reg_dst;
    logic [ALU_OP_W-1:0]   alu_op;
    logic [DATA_W-1:0]     read_data1;
    logic [DATA_W-1:0]     read_data2;
    logic [DATA_W-1:0]     imm;
  } id_ex_t;

  // A bubble is an all-zero stage: invalid, no side-effecting controls.
  localparam id_ex_t ID_EX_BUBBLE = '0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: a valid load in EX whose destination
// (rt, never $zero) is a source of the valid instruction in ID.
module load_use_detect
  import mips_pkg::*;
(
  input  logic                  ex_valid,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  output logic                  hazard
);

  logic rt_nonzero;
  logic src_match;

  always_comb begin
    rt_nonzero = (ex_rt != '0);
    // A match on both sources is still a single hazard.
    src_match  = (ex_rt == id_rs) || (ex_rt == id_rt);
    hazard     = ex_valid && ex_mem_read && rt_nonzero && id_valid && src_match;
  end

endmodule

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use stall FSM (RUN/BUBBLE) and flush.
// Optional STALL_COUNTER_EN adds a saturating 16-bit hazard-bubble counter.
module id_ex_hazard_reg
  import mips_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  id_mem_write,
  input  logic                  id_mem_to_reg,
  input  logic                  id_alu_src,
  input  logic                  id_reg_dst,
  input  logic [ALU_OP_W-1:0]   id_alu_op,
  input  logic [DATA_W-1:0]     id_read_data1,
  input  logic [DATA_W-1:0]     id_read_data2,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic                  flush,
  output logic                  ex_valid,
  output logic [REG_ADDR_W-1:0] ex_rs,
  output logic [REG_ADDR_W-1:0] ex_rt,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic                  ex_mem_write,
  output logic                  ex_mem_to_reg,
  output logic                  ex_alu_src,
  output logic                  ex_reg_dst,
  output logic [ALU_OP_W-1:0]   ex_alu_op,
  output logic [DATA_W-1:0]     ex_read_data1,
  output logic [DATA_W-1:0]     ex_read_data2,
  output logic [DATA_W-1:0]     ex_imm,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  stall_state
`ifdef STALL_COUNTER_EN
  ,
  output logic [15:0]           stall_count
`endif
);

  id_ex_t    id_stage;
  id_ex_t    ex_d, ex_q;
  hz_state_e state_d, state_q;
  logic      hazard_raw;
  logic      hazard;
  logic      stall_now;

  load_use_detect u_detect (
    .ex_valid    (ex_q.valid),
    .ex_mem_read (ex_q.mem_read),
    .ex_rt       (ex_q.rt),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .hazard      (hazard_raw)
  );

  always_comb begin
    id_stage.valid      = id_valid;
    id_stage.rs         = id_rs;
    id_stage.rt         = id_rt;
    id_stage.rd         = id_rd;
    id_stage.reg_write  = id_reg_write;
    id_stage.mem_read   = id_mem_read;
    id_stage.mem_write  = id_mem_write;
    id_stage.mem_to_reg = id_mem_to_reg;
    id_stage.alu_src    = id_alu_src;
    id_stage.reg_dst    = id_reg_dst;
    id_stage.alu_op     = id_alu_op;
    id_stage.read_data1 = id_read_data1;
    id_stage.read_data2 = id_read_data2;
    id_stage.imm        = id_imm;
  end

  // pc_write/if_id_write are the stage's "ready" back to IF: when low, IF and
  // IF/ID must hold so the stalled ID instruction is presented again.
  always_comb begin
    state_d     = ST_RUN;
    hazard      = hazard_raw && (state_q == ST_RUN);
    stall_now   = hazard && !flush;
    ex_d        = id_stage;
    pc_write    = 1'b1;
    if_id_write = 1'b1;

    case (state_q)
      ST_RUN:    state_d = stall_now ? ST_BUBBLE : ST_RUN;
      ST_BUBBLE: state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase

    if (flush || hazard) begin
      ex_d = ID_EX_BUBBLE;
    end
    if (stall_now && !rst) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      ex_q    <= ID_EX_BUBBLE;
    end else begin
      state_q <= state_d;
      ex_q    <= ex_d;
    end
  end

`ifdef STALL_COUNTER_EN
  logic [15:0] stall_cnt_d, stall_cnt_q;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_now && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
`endif

  assign ex_valid      = ex_q.valid;
  assign ex_rs         = ex_q.rs;
  assign ex_rt         = ex_q.rt;
  assign ex_rd         = ex_q.rd;
  assign ex_reg_write  = ex_q.reg_write;
  assign ex_mem_read   = ex_q.mem_read;
  assign ex_mem_write  = ex_q.mem_write;
  assign ex_mem_to_reg = ex_q.mem_to_reg;
  assign ex_alu_src    = ex_q.alu_src;
  assign ex_reg_dst    = ex_q.reg_dst;
  assign ex_alu_op     = ex_q.alu_op;
  assign ex_read_data1 = ex_q.read_data1;
  assign ex_read_data2 = ex_q.read_data2;
  assign ex_imm        = ex_q.imm;
  assign stall_state   = (state_q == ST_BUBBLE);

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Bench for id_ex_hazard_reg: directed load-use/flush/reset scenarios plus
// random traffic, all checked every cycle against a behavioural model.
module tb_id_ex_hazard_reg;

  typedef struct packed {
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_dst;
    logic [2:0] alu_op;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
  } ex_t;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        id_alu_src, id_reg_dst;
  logic [2:0]  id_alu_op;
  logic [31:0] id_read_data1, id_read_data2, id_imm;
  logic        flush;
  logic        ex_valid;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;
  logic        ex_alu_src, ex_reg_dst;
  logic [2:0]  ex_alu_op;
  logic [31:0] ex_read_data1, ex_read_data2, ex_imm;
  logic        pc_write, if_id_write, stall_state;
`ifdef STALL_COUNTER_EN
  logic [15:0] stall_count;
`endif

  int total = 0;
  int bad   = 0;

  id_ex_hazard_reg dut (
    .clk           (clk),
    .rst           (rst),
    .id_valid      (id_valid),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_rd         (id_rd),
    .id_reg_write  (id_reg_write),
    .id_mem_read   (id_mem_read),
    .id_mem_write  (id_mem_write),
    .id_mem_to_reg (id_mem_to_reg),
    .id_alu_src    (id_alu_src),
    .id_reg_dst    (id_reg_dst),
    .id_alu_op     (id_alu_op),
    .id_read_data1 (id_read_data1),
    .id_read_data2 (id_read_data2),
    .id_imm        (id_imm),
    .flush         (flush),
    .ex_valid      (ex_valid),
    .ex_rs         (ex_rs),
    .ex_rt         (ex_rt),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_mem_to_reg (ex_mem_to_reg),
    .ex_alu_src    (ex_alu_src),
    .ex_reg_dst    (ex_reg_dst),
    .ex_alu_op     (ex_alu_op),
    .ex_read_data1 (ex_read_data1),
    .ex_read_data2 (ex_read_data2),
    .ex_imm        (ex_imm),
    .pc_write      (pc_write),
    .if_id_write   (if_id_write),
    .stall_state   (stall_state)
`ifdef STALL_COUNTER_EN
    ,
    .stall_count   (stall_count)
`endif
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking helper ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  ex_t         id_now, dut_ex, exp_ex;
  logic        exp_stall;
  logic        model_live = 1'b0;
  logic [15:0] exp_cnt;

  assign id_now = '{id_valid, id_rs, id_rt, id_rd, id_reg_write, id_mem_read,
                    id_mem_write, id_mem_to_reg, id_alu_src, id_reg_dst,
                    id_alu_op, id_read_data1, id_read_data2, id_imm};
  assign dut_ex = '{ex_valid, ex_rs, ex_rt, ex_rd, ex_reg_write, ex_mem_read,
                    ex_mem_write, ex_mem_to_reg, ex_alu_src, ex_reg_dst,
                    ex_alu_op, ex_read_data1, ex_read_data2, ex_imm};

  // Load-use: the instruction now in EX loads into a nonzero register
  // that the valid ID instruction reads.
  function automatic logic model_hazard();
    return exp_ex.valid && exp_ex.mem_read && (exp_ex.rt != 5'd0) && id_valid &&
           (exp_ex.rt == id_rs || exp_ex.rt == id_rt);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      exp_ex     = '0;
      exp_stall  = 1'b0;
      exp_cnt    = 16'd0;
      model_live = 1'b1;
    end else if (flush) begin
      exp_ex    = '0;
      exp_stall = 1'b0;
    end else if (model_hazard()) begin
      exp_ex    = '0;
      exp_stall = 1'b1;
      if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    end else begin
      exp_ex    = id_now;
      exp_stall = 1'b0;
    end
  end

  // Single compare process: registered state and load enables every cycle.
  always @(negedge clk) begin
    if (model_live) begin
      check("ex_bundle", 128'(dut_ex), 128'(exp_ex));
      check("stall_state", 128'(stall_state), 128'(exp_stall));
      check("pc_write", 128'(pc_write), 128'(rst || flush || !model_hazard()));
      check("if_id_write", 128'(if_id_write), 128'(rst || flush || !model_hazard()));
`ifdef STALL_COUNTER_EN
      check("stall_count", 128'(stall_count), 128'(exp_cnt));
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic set_instr(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                           input logic [4:0] rd, input logic mr);
    id_valid      = v;
    id_rs         = rs;
    id_rt         = rt;
    id_rd         = rd;
    id_mem_read   = mr;
    id_reg_write  = 1'b1;
    id_mem_write  = 1'b0;
    id_mem_to_reg = mr;
    id_alu_src    = mr;
    id_reg_dst    = !mr;
    id_alu_op     = 3'($urandom_range(0, 7));
    id_read_data1 = $urandom;
    id_read_data2 = $urandom;
    id_imm        = $urandom;
  endtask

  task automatic rand_id();
    id_valid      = ($urandom_range(0, 3) != 0);
    id_rs         = 5'($urandom_range(0, 3));
    id_rt         = 5'($urandom_range(0, 3));
    id_rd         = 5'($urandom_range(0, 31));
    id_reg_write  = 1'($urandom);
    id_mem_read   = 1'($urandom);
    id_mem_write  = 1'($urandom);
    id_mem_to_reg = 1'($urandom);
    id_alu_src    = 1'($urandom);
    id_reg_dst    = 1'($urandom);
    id_alu_op     = 3'($urandom);
    id_read_data1 = $urandom;
    id_read_data2 = $urandom;
    id_imm        = $urandom;
  endtask

  task automatic load_use_pair(input logic do_flush);
    set_instr(1'b1, 5'd9, 5'd8, 5'd0, 1'b1);
    cyc();
    set_instr(1'b1, 5'd8, 5'd10, 5'd11, 1'b0);
    flush = do_flush;
    cyc();
    flush = 1'b0;
    cyc();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    flush = 1'b1;
    rand_id();
    cyc();
    cyc();
    @(negedge clk);
    check("rst_pc_write", 128'(pc_write), 128'(1));
    check("rst_ex_valid", 128'(ex_valid), 128'(0));
    check("rst_ex_imm", 128'(ex_imm), 128'(0));
    rst = 1'b0;
    flush = 1'b0;
    cyc();

    // lw $t0 then dependent add: one bubble, then the add enters EX
    set_instr(1'b1, 5'd9, 5'd8, 5'd0, 1'b1);
    cyc();
    set_instr(1'b1, 5'd8, 5'd10, 5'd11, 1'b0);
    @(negedge clk);
    check("lu_pc_write", 128'(pc_write), 128'(0));
    check("lu_if_id_write", 128'(if_id_write), 128'(0));
    cyc();
    @(negedge clk);
    check("lu_bubble_valid", 128'(ex_valid), 128'(0));
    check("lu_stall_state", 128'(stall_state), 128'(1));
    check("lu_bubble_pc", 128'(pc_write), 128'(1));
    cyc();
    @(negedge clk);
    check("lu_add_valid", 128'(ex_valid), 128'(1));
    check("lu_add_rs", 128'(ex_rs), 128'(8));
    check("lu_add_stall", 128'(stall_state), 128'(0));

    // load into $zero never stalls
    set_instr(1'b1, 5'd9, 5'd0, 5'd0, 1'b1);
    cyc();
    set_instr(1'b1, 5'd0, 5'd0, 5'd12, 1'b0);
    @(negedge clk);
    check("r0_pc_write", 128'(pc_write), 128'(1));
    cyc();
    @(negedge clk);
    check("r0_add_rd", 128'(ex_rd), 128'(12));
    check("r0_stall", 128'(stall_state), 128'(0));

    // hazard together with flush: bubble, no stall
    set_instr(1'b1, 5'd9, 5'd8, 5'd0, 1'b1);
    cyc();
    set_instr(1'b1, 5'd8, 5'd8, 5'd13, 1'b0);
    flush = 1'b1;
    @(negedge clk);
    check("fl_pc_write", 128'(pc_write), 128'(1));
    cyc();
    flush = 1'b0;
    @(negedge clk);
    check("fl_ex_valid", 128'(ex_valid), 128'(0));
    check("fl_stall", 128'(stall_state), 128'(0));

    // reset while in BUBBLE abandons the bubble
    set_instr(1'b1, 5'd9, 5'd8, 5'd0, 1'b1);
    cyc();
    set_instr(1'b1, 5'd8, 5'd8, 5'd14, 1'b0);
    cyc();
    rst = 1'b1;
    @(negedge clk);
    check("rb_in_bubble", 128'(stall_state), 128'(1));
    check("rb_pc_write", 128'(pc_write), 128'(1));
    cyc();
    rst = 1'b0;
    @(negedge clk);
    check("rb_stall", 128'(stall_state), 128'(0));
    check("rb_ex_valid", 128'(ex_valid), 128'(0));
    check("rb_ex_rd", 128'(ex_rd), 128'(0));

    // five independent ALU instructions flow with one-cycle latency
    for (int i = 0; i < 5; i++) begin
      set_instr(1'b1, 5'(16 + i), 5'(21 + i), 5'(1 + i), 1'b0);
      @(negedge clk);
      check("ind_pc_write", 128'(pc_write), 128'(1));
      cyc();
      @(negedge clk);
      check("ind_ex_rs", 128'(ex_rs), 128'(16 + i));
      check("ind_ex_rd", 128'(ex_rd), 128'(1 + i));
    end

    // back-to-back loads, each dependent on the previous: one bubble each
    set_instr(1'b1, 5'd9, 5'd8, 5'd0, 1'b1);
    cyc();
    set_instr(1'b1, 5'd8, 5'd7, 5'd0, 1'b1);
    cyc();
    cyc();
    set_instr(1'b1, 5'd7, 5'd2, 5'd3, 1'b0);
    @(negedge clk);
    check("b2b_second_stall", 128'(pc_write), 128'(0));
    cyc();
    cyc();

`ifdef STALL_COUNTER_EN
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) load_use_pair(1'b0);
    for (int i = 0; i < 2; i++) load_use_pair(1'b1);
    @(negedge clk);
    check("cnt_three", 128'(stall_count), 128'(3));
    cyc();
    force dut.stall_cnt_q = 16'hFFFE;
    exp_cnt = 16'hFFFE;
    #1;
    release dut.stall_cnt_q;
    for (int i = 0; i < 3; i++) load_use_pair(1'b0);
    @(negedge clk);
    check("cnt_saturate", 128'(stall_count), 128'hFFFF);
    cyc();
`endif

    // random traffic with narrow register numbers to provoke hazards
    for (int i = 0; i < 3000; i++) begin
      rand_id();
      flush = ($urandom_range(0, 7) == 0);
      rst   = ($urandom_range(0, 63) == 0);
      cyc();
    end
    rst = 1'b0;
    flush = 1'b0;
    cyc();
    @(negedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
